// File: rtl/fp_mult_result_collector.sv
// Result collector behind the FP multiplier pipeline.
// Captures each (z, status) pair into a first-word-fall-through FIFO with a valid/ready output.
// The multiplier cannot be stalled, so pushes into a full FIFO are dropped and counted instead.
// Sticky status/overflow flags and saturating result/drop counters are kept for inspection.
module fp_mult_result_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_z,
    input  logic [7:0]               in_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [7:0]               out_status,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic                     sticky_clr,
    output logic [7:0]               sticky_status,
    output logic                     overflow,
    output logic [CNT_W-1:0]         result_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      z_mem [DEPTH];
    logic [7:0]       s_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [7:0]       sticky_q, sticky_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             push, pop, drop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign out_valid = !empty;

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && !push;

    // Next-state for pointers, occupancy, sticky flags and saturating counters.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        result_cnt_d = result_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (push && (result_cnt_q != CNT_MAX)) begin
            result_cnt_d = result_cnt_q + 1'b1;
        end
        if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end

        // Clear first, then OR in this cycle's event so a same-cycle push/drop survives the clear.
        sticky_d   = (sticky_clr ? 8'h00 : sticky_q) | (push ? in_status : 8'h00);
        overflow_d = (sticky_clr ? 1'b0 : overflow_q) | drop;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sticky_q     <= '0;
            overflow_q   <= 1'b0;
            result_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sticky_q     <= sticky_d;
            overflow_q   <= overflow_d;
            result_cnt_q <= result_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage write; no reset needed since empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            z_mem[wr_ptr_q] <= in_z;
            s_mem[wr_ptr_q] <= in_status;
        end
    end

    assign out_z         = empty ? 32'h0 : z_mem[rd_ptr_q];
    assign out_status    = empty ? 8'h00 : s_mem[rd_ptr_q];
    assign count         = count_q;
    assign sticky_status = sticky_q;
    assign overflow      = overflow_q;
    assign result_cnt    = result_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_fp_mult_result_collector.sv
// Bench for fp_mult_result_collector: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_fp_mult_result_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [31:0]            in_z = '0;
    logic [7:0]             in_status = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [31:0]            out_z;
    logic [7:0]             out_status;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   sticky_clr = 1'b0;
    logic [7:0]             sticky_status;
    logic                   overflow;
    logic [CNT_W-1:0]       result_cnt;
    logic [CNT_W-1:0]       drop_cnt;

    fp_mult_result_collector #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_z         (in_z),
        .in_status    (in_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_status   (out_status),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .sticky_clr   (sticky_clr),
        .sticky_status(sticky_status),
        .overflow     (overflow),
        .result_cnt   (result_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of {status, z} plus plain counters.
    logic [39:0] m_q[$];
    int          m_res = 0;
    int          m_drop = 0;
    logic [7:0]  m_sticky = '0;
    logic        m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = m_q.size();
        logic [39:0] head = (n > 0) ? m_q[0] : 40'h0;
        check("count", 32'(count), 32'(n));
        check("out_valid", 32'(out_valid), 32'(n > 0));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("out_z", out_z, head[31:0]);
        check("out_status", 32'(out_status), 32'(head[39:32]));
        check("sticky_status", 32'(sticky_status), 32'(m_sticky));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("result_cnt", 32'(result_cnt), 32'(m_res));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // Called at a negedge: check current state, apply inputs, advance model and clock.
    task automatic step(input logic v, input logic [31:0] z, input logic [7:0] s,
                        input logic rdy, input logic clr, input logic r);
        bit do_pop, do_push, do_drop;
        check_all();
        in_valid   = v;
        in_z       = z;
        in_status  = s;
        out_ready  = rdy;
        sticky_clr = clr;
        rst        = r;
        if (r) begin
            m_q.delete();
            m_res = 0;
            m_drop = 0;
            m_sticky = '0;
            m_ovf = 1'b0;
        end else begin
            do_pop  = (m_q.size() > 0) && rdy;
            do_push = v && ((m_q.size() < DEPTH) || do_pop);
            do_drop = v && !do_push;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back({s, z});
            if (do_push && m_res < CMAX) m_res++;
            if (do_drop && m_drop < CMAX) m_drop++;
            m_sticky = (clr ? 8'h00 : m_sticky) | (do_push ? s : 8'h00);
            m_ovf    = (clr ? 1'b0 : m_ovf) | do_drop;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Initial reset; outputs are undefined before the first edge so no checks yet.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b0);

        // Single result, held 3 cycles, then popped.
        step(1'b1, 32'h3F800000, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("plan_result_cnt", 32'(result_cnt), 32'd1);

        // Fill past capacity: two drops.
        for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), 8'h00, 1'b0, 1'b0, 1'b0);
        check("plan_drop_cnt", 32'(drop_cnt), 32'd2);
        check("plan_full", 32'(full), 32'd1);
        // Full with simultaneous push and pop, then drain through wrap-around.
        step(1'b1, 32'hDEADBEEF, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Sticky accumulation and a clear coinciding with a push.
        step(1'b1, 32'h11, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h22, 8'h04, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h33, 8'h80, 1'b1, 1'b0, 1'b0);
        check("plan_sticky_acc", 32'(sticky_status), 32'h85);
        step(1'b1, 32'h44, 8'h10, 1'b1, 1'b1, 1'b0);
        check("plan_sticky_clr", 32'(sticky_status), 32'h10);
        check("plan_ovf_clr", 32'(overflow), 32'd0);

        // Reach count=5 with overflow set, then reset mid-stream with push and pop active.
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hCAFEF00D, 8'hFF, 1'b1, 1'b0, 1'b1);
        check("plan_rst_count", 32'(count), 32'd0);

        // Randomized traffic with varying push/pop pressure and rare resets.
        for (int ph = 0; ph < 6; ph++) begin
            int pv = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 20 : 55;
            int pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 90 : 55;
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(99) < pv, $urandom, 8'($urandom),
                     $urandom_range(99) < pr, $urandom_range(19) == 0,
                     $urandom_range(299) == 0);
            end
        end
        check_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_result_collector.md
Name: fp_mult_result_collector

Overview:
Downstream stage of fp_mult_top: captures each result word z and its 8-bit status as the multiplier pipeline produces them, and buffers them in a first-word-fall-through FIFO with a valid/ready output. The multiplier cannot be stalled, so the collector never backpressures it. When the FIFO is full, incoming results are dropped and counted. It also keeps a sticky OR of all accepted status bits, plus result and drop counters, for software or bench inspection.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 16, width of result_cnt and drop_cnt (saturating)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  multiplier result valid this cycle
in_z  input  32  multiplier result word (z)
in_status  input  8  multiplier status flags for in_z
out_valid  output  1  head entry valid (= !empty)
out_ready  input  1  consumer accepts head this cycle
out_z  output  32  head result word
out_status  output  8  head status
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
sticky_clr  input  1  clear sticky_status and overflow
sticky_status  output  8  OR of in_status over all accepted pushes since last clear/reset
overflow  output  1  sticky: at least one push dropped since last clear/reset
result_cnt  output  CNT_W  accepted pushes since reset, saturating
drop_cnt  output  CNT_W  dropped pushes since reset, saturating

Behaviour:
- Reset (rst=1 at a clk edge): count=0, empty=1, full=0, out_valid=0, out_z=0, out_status=0, sticky_status=0, overflow=0, result_cnt=0, drop_cnt=0. Read/write pointers go to 0. Reset overrides every other input in that cycle. Any buffered entries are discarded when reset is asserted mid-stream.
- Push: in_valid=1 and (!full or pop this cycle) -> entry written at the write pointer, pointer incremented mod DEPTH.
- Pop: out_valid && out_ready -> read pointer incremented mod DEPTH. out_ready while empty is ignored.
- Full + push + pop in the same cycle: both happen. count stays DEPTH and nothing is dropped.
- Full + push without pop: push dropped. drop_cnt increments (saturating at 2^CNT_W-1) and overflow is set. FIFO contents and sticky_status are unchanged.
- Empty + push + out_ready in the same cycle: no bypass. The entry appears on out_z/out_status with out_valid=1 on the next cycle (push-to-output latency is 1 cycle).
- out_z/out_status are combinational reads of the head entry. They hold stable while out_valid=1 and out_ready=0. When empty they show 0.
- count updates each cycle: +1 on push only, -1 on pop only, unchanged on both or neither. full and empty are derived from count.
- result_cnt increments on every accepted push and saturates at all-ones.
- sticky_status next value: (sticky_clr ? 0 : sticky_status) | (accepted push ? in_status : 0). A push arriving in the same cycle as a clear is therefore retained.
- overflow next value: (sticky_clr ? 0 : overflow) | drop_this_cycle. A drop in the same cycle as a clear leaves overflow=1.
- sticky_clr does not affect FIFO contents, result_cnt or drop_cnt.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- No X propagation: in_z/in_status are ignored when in_valid=0.

Test Plan:
- Reset then idle: after rst=1 for 1 cycle, then rst=0 for 5 cycles with in_valid=0 -> all outputs 0, empty=1, out_valid=0.
- Single result: push in_z=0x3F800000, in_status=0x00 at cycle N -> out_valid=1 at N+1 with out_z=0x3F800000. Hold out_ready=0 for 3 cycles: output stable. Pulse out_ready: empty=1 the next cycle. result_cnt=1.
- Fill and overflow (DEPTH=8): push 10 consecutive words 0x00000001..0x0000000A with out_ready=0 -> count=8, full=1, drop_cnt=2, overflow=1. Then drain with out_ready=1: out_z sequence is 0x01..0x08, then empty=1.
- Full with simultaneous push/pop: at count=8, push 0xDEADBEEF with out_ready=1 -> count stays 8, drop_cnt unchanged. 0xDEADBEEF is popped 8th after that cycle (wrap-around of both pointers exercised).
- Sticky flags: push statuses 0x01, 0x04, 0x80 -> sticky_status=0x85. Assert sticky_clr in the same cycle as a push with status 0x10 -> sticky_status=0x10 and overflow cleared. Counters untouched.
- Reset mid-stream: with count=5 and overflow=1, assert rst while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, all counters and sticky outputs 0. The in-flight push is not stored.
